// File: rtl/decode_queue_if.sv
// Fetch-to-issue bus for the buffered decode stage: a valid/ready push side
// carrying raw instructions with their PCs, and a valid/ready pop side
// carrying the fully decoded head entry.
interface decode_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [5:0]  out_fmt;
    logic [31:0] out_imm;
    logic        out_is_load;
    logic        out_is_store;
    logic        out_uses_rs1;
    logic        out_uses_rs2;
    logic        out_writes_rd;
    logic        out_illegal;

    // Environment side: fetch drives the push channel, issue drives out_ready.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_fmt, out_imm, out_is_load,
               out_is_store, out_uses_rs1, out_uses_rs2, out_writes_rd,
               out_illegal
    );

    // Queue side.
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_funct3, out_funct7,
               out_rd, out_rs1, out_rs2, out_fmt, out_imm, out_is_load,
               out_is_store, out_uses_rs1, out_uses_rs2, out_writes_rd,
               out_illegal
    );
endinterface

// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: a DEPTH-entry circular FIFO of {instr, pc}
// whose head entry is decoded combinationally from storage. There is no
// combinational path from the push side to the pop side.
module decode_queue #(
    parameter int DEPTH    = 4,
    parameter int ENABLE_M = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    decode_queue_if.slave            bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic push;
    logic pop;
    logic not_empty;

    logic [31:0] head_instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        fmt_r, fmt_i, fmt_s, fmt_b, fmt_u, fmt_j, is_fence;
    logic [31:0] imm;
    logic        illegal;
    logic        writes_rd;

    assign not_empty    = (count != '0);
    assign bus.in_ready = (count != CW'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = not_empty & bus.out_ready;

    // Pointer and occupancy bookkeeping; reset beats flush, flush drops any push.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset because occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            instr_mem[wr_ptr] <= bus.in_instr;
            pc_mem[wr_ptr]    <= bus.in_pc;
        end
    end

    // Decode the head entry: format, immediate and legality.
    always_comb begin
        head_instr = instr_mem[rd_ptr];
        opcode     = head_instr[6:0];
        funct3     = head_instr[14:12];
        funct7     = head_instr[31:25];
        fmt_r      = 1'b0;
        fmt_i      = 1'b0;
        fmt_s      = 1'b0;
        fmt_b      = 1'b0;
        fmt_u      = 1'b0;
        fmt_j      = 1'b0;
        is_fence   = 1'b0;
        imm        = '0;
        illegal    = 1'b0;
        case (opcode)
            7'b0110011: fmt_r = 1'b1;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt_i = 1'b1;
            7'b0100011: fmt_s = 1'b1;
            7'b1100011: fmt_b = 1'b1;
            7'b0110111, 7'b0010111: fmt_u = 1'b1;
            7'b1101111: fmt_j = 1'b1;
            7'b0001111: is_fence = 1'b1;
            default:    illegal = 1'b1;
        endcase
        if (fmt_i) imm = {{20{head_instr[31]}}, head_instr[31:20]};
        if (fmt_s) imm = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
        if (fmt_b) imm = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                          head_instr[30:25], head_instr[11:8], 1'b0};
        if (fmt_u) imm = {head_instr[31:12], 12'b0};
        if (fmt_j) imm = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                          head_instr[20], head_instr[30:21], 1'b0};
        if (head_instr[1:0] != 2'b11) illegal = 1'b1;
        if (fmt_r) begin
            if (!(funct7 == 7'b0000000 || funct7 == 7'b0100000 ||
                  (ENABLE_M != 0 && funct7 == 7'b0000001)))
                illegal = 1'b1;
            if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101)
                illegal = 1'b1;
        end
        if (opcode == 7'b0000011 && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
            illegal = 1'b1;
        if (opcode == 7'b0100011 && funct3 > 3'b010)
            illegal = 1'b1;
        if (opcode == 7'b1100011 && (funct3 == 3'b010 || funct3 == 3'b011))
            illegal = 1'b1;
        if (opcode == 7'b1100111 && funct3 != 3'b000)
            illegal = 1'b1;
        writes_rd = (fmt_r | fmt_i | fmt_u | fmt_j) && (head_instr[11:7] != 5'd0);
    end

    // Drive the pop side, forcing every data output to zero while empty.
    always_comb begin
        bus.out_valid     = not_empty;
        bus.out_pc        = '0;
        bus.out_opcode    = '0;
        bus.out_funct3    = '0;
        bus.out_funct7    = '0;
        bus.out_rd        = '0;
        bus.out_rs1       = '0;
        bus.out_rs2       = '0;
        bus.out_fmt       = '0;
        bus.out_imm       = '0;
        bus.out_is_load   = 1'b0;
        bus.out_is_store  = 1'b0;
        bus.out_uses_rs1  = 1'b0;
        bus.out_uses_rs2  = 1'b0;
        bus.out_writes_rd = 1'b0;
        bus.out_illegal   = 1'b0;
        if (not_empty) begin
            bus.out_pc        = pc_mem[rd_ptr];
            bus.out_opcode    = opcode;
            bus.out_funct3    = funct3;
            bus.out_funct7    = funct7;
            bus.out_rd        = head_instr[11:7];
            bus.out_rs1       = head_instr[19:15];
            bus.out_rs2       = head_instr[24:20];
            bus.out_fmt       = {fmt_j, fmt_u, fmt_b, fmt_s, fmt_i, fmt_r};
            bus.out_imm       = imm;
            bus.out_is_load   = (opcode == 7'b0000011);
            bus.out_is_store  = (opcode == 7'b0100011);
            bus.out_uses_rs1  = fmt_r | fmt_i | fmt_s | fmt_b;
            bus.out_uses_rs2  = fmt_r | fmt_s | fmt_b;
            bus.out_writes_rd = writes_rd;
            bus.out_illegal   = illegal;
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue. Two copies run on the same stimulus, one
// without and one with the M extension, so MUL legality can be compared.
module tb_decode_queue;
    logic        clk;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic [31:0] inInstr;
    logic [31:0] inPc;
    logic        outReady;
    logic [2:0]  count0;
    logic [2:0]  count1;

    int numChecks;
    int numFails;

    decode_queue_if bus0();
    decode_queue_if bus1();

    assign bus0.in_valid  = inValid;
    assign bus0.in_instr  = inInstr;
    assign bus0.in_pc     = inPc;
    assign bus0.out_ready = outReady;
    assign bus1.in_valid  = inValid;
    assign bus1.in_instr  = inInstr;
    assign bus1.in_pc     = inPc;
    assign bus1.out_ready = outReady;

    decode_queue #(.DEPTH(4), .ENABLE_M(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .count(count0));
    decode_queue #(.DEPTH(4), .ENABLE_M(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .count(count1));

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  fmt;
        logic [31:0] imm;
        logic [5:0]  flags;
    } vec_t;

    // flags = {is_load, is_store, uses_rs1, uses_rs2, writes_rd, illegal}
    vec_t vecs [11];
    initial begin
        vecs[0]  = '{32'hFE000EE3, 6'b001000, 32'hFFFFFFFC, 6'b001100};
        vecs[1]  = '{32'h0020A423, 6'b000100, 32'h00000008, 6'b011100};
        vecs[2]  = '{32'h123452B7, 6'b010000, 32'h12345000, 6'b000010};
        vecs[3]  = '{32'h800000EF, 6'b100000, 32'hFFF00000, 6'b000010};
        vecs[4]  = '{32'h00003003, 6'b000010, 32'h00000000, 6'b101001};
        vecs[5]  = '{32'h40001033, 6'b000001, 32'h00000000, 6'b001101};
        vecs[6]  = '{32'h0000000F, 6'b000000, 32'h00000000, 6'b000000};
        vecs[7]  = '{32'hFFC12183, 6'b000010, 32'hFFFFFFFC, 6'b101010};
        vecs[8]  = '{32'h00001067, 6'b000010, 32'h00000000, 6'b001001};
        vecs[9]  = '{32'h402081B3, 6'b000001, 32'h00000000, 6'b001110};
        vecs[10] = '{32'h00000000, 6'b000000, 32'h00000000, 6'b000001};
    end

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then settle 1 unit past the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] instr,
                                 input logic [31:0] pc, input logic rdy,
                                 input logic fl);
        inValid  = v;
        inInstr  = instr;
        inPc     = pc;
        outReady = rdy;
        flush    = fl;
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        outReady = 1'b0;
        flush    = 1'b0;
    endtask

    function automatic logic [5:0] flagsOf0();
        return {bus0.out_is_load, bus0.out_is_store, bus0.out_uses_rs1,
                bus0.out_uses_rs2, bus0.out_writes_rd, bus0.out_illegal};
    endfunction

    // Main directed sequence.
    initial begin
        numChecks = 0;
        numFails  = 0;
        rst = 1'b1; flush = 1'b0; inValid = 1'b0; inInstr = '0; inPc = '0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_count", 32'(count0), 0);
        checkOutput("reset_out_valid", 32'(bus0.out_valid), 0);
        checkOutput("reset_in_ready", 32'(bus0.in_ready), 1);
        checkOutput("reset_imm", bus0.out_imm, 0);

        // addi x1,x0,-1 visible the cycle after the push
        applyStimulus(1'b1, 32'hFFF00093, 32'h100, 1'b0, 1'b0);
        checkOutput("addi_valid", 32'(bus0.out_valid), 1);
        checkOutput("addi_pc", bus0.out_pc, 32'h100);
        checkOutput("addi_fmt", 32'(bus0.out_fmt), 32'b000010);
        checkOutput("addi_rd", 32'(bus0.out_rd), 1);
        checkOutput("addi_imm", bus0.out_imm, 32'hFFFFFFFF);
        checkOutput("addi_flags", 32'(flagsOf0()), 32'b001010);
        checkOutput("addi_count", 32'(count0), 1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("addi_popped", 32'(bus0.out_valid), 0);

        // Decode table: push, check head, pop
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
            checkOutput($sformatf("vec%0d_pc", i), bus0.out_pc, 32'h1000 + 32'(i * 4));
            checkOutput($sformatf("vec%0d_opcode", i), 32'(bus0.out_opcode), 32'(vecs[i].instr[6:0]));
            checkOutput($sformatf("vec%0d_fmt", i), 32'(bus0.out_fmt), 32'(vecs[i].fmt));
            checkOutput($sformatf("vec%0d_imm", i), bus0.out_imm, vecs[i].imm);
            checkOutput($sformatf("vec%0d_flags", i), 32'(flagsOf0()), 32'(vecs[i].flags));
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        end

        // Fill to capacity with out_ready low; fifth push refused
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fill%0d_in_ready", i), 32'(bus0.in_ready), 1);
            applyStimulus(1'b1, 32'h00000013, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
        end
        checkOutput("full_count", 32'(count0), 4);
        checkOutput("full_in_ready", 32'(bus0.in_ready), 0);
        applyStimulus(1'b1, 32'h00000013, 32'h210, 1'b0, 1'b0);
        checkOutput("fifth_rejected_count", 32'(count0), 4);
        checkOutput("full_head_pc", bus0.out_pc, 32'h200);

        // Full with push and pop requested: pop only
        applyStimulus(1'b1, 32'h00000013, 32'h300, 1'b1, 1'b0);
        checkOutput("full_pop_count", 32'(count0), 3);
        checkOutput("full_pop_head", bus0.out_pc, 32'h204);
        applyStimulus(1'b1, 32'h00000013, 32'h310, 1'b1, 1'b0);
        checkOutput("push_pop_count", 32'(count0), 3);
        checkOutput("push_pop_head", bus0.out_pc, 32'h208);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("drain0_pc", bus0.out_pc, 32'h20C);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("drain1_pc", bus0.out_pc, 32'h310);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("drain_empty", 32'(bus0.out_valid), 0);
        checkOutput("drain_count", 32'(count0), 0);

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 32'hFFF00093, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
        checkOutput("preflush_count", 32'(count0), 3);
        applyStimulus(1'b1, 32'h123452B7, 32'h4F0, 1'b0, 1'b1);
        checkOutput("flush_count", 32'(count0), 0);
        checkOutput("flush_valid", 32'(bus0.out_valid), 0);
        checkOutput("flush_pc", bus0.out_pc, 0);
        checkOutput("flush_imm", bus0.out_imm, 0);
        checkOutput("flush_opcode", 32'(bus0.out_opcode), 0);
        checkOutput("flush_fmt", 32'(bus0.out_fmt), 0);
        checkOutput("flush_rd", 32'(bus0.out_rd), 0);
        checkOutput("flush_in_ready", 32'(bus0.in_ready), 1);
        applyStimulus(1'b1, 32'h00000013, 32'h500, 1'b0, 1'b0);
        checkOutput("postflush_count", 32'(count0), 1);
        checkOutput("postflush_pc", bus0.out_pc, 32'h500);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

        // Zero word then MUL, checked on both configurations
        applyStimulus(1'b1, 32'h00000000, 32'h600, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h02208033, 32'h604, 1'b0, 1'b0);
        checkOutput("zero_illegal_m0", 32'(bus0.out_illegal), 1);
        checkOutput("zero_illegal_m1", 32'(bus1.out_illegal), 1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("mul_pc", bus0.out_pc, 32'h604);
        checkOutput("mul_illegal_m0", 32'(bus0.out_illegal), 1);
        checkOutput("mul_illegal_m1", 32'(bus1.out_illegal), 0);
        checkOutput("mul_writes_rd_m0", 32'(bus0.out_writes_rd), 0);
        checkOutput("mul_writes_rd_m1", 32'(bus1.out_writes_rd), 0);
        checkOutput("mul_fmt", 32'(bus1.out_fmt), 32'b000001);
        checkOutput("mul_rs1", 32'(bus1.out_rs1), 1);
        checkOutput("mul_rs2", 32'(bus1.out_rs2), 2);
        checkOutput("mul_funct7", 32'(bus1.out_funct7), 1);
        checkOutput("mul_count_m1", 32'(count1), 1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("final_empty", 32'(bus1.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
